// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module  : hazard_scoreboard
// Purpose : D-stage interlock. Tracks E/M/W writers and raises stall and forward selects.
//           Optional stall counter enabled by macro STALL_CNT_EN.
// Revision: 1.0 - initial release
// ============================================================================
module hazard_scoreboard #(
    parameter int REG_W = 5,
    parameter int T_W   = 2,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             d_valid,
    input  logic [REG_W-1:0] d_rs,
    input  logic [REG_W-1:0] d_rt,
    input  logic             d_read_rs,
    input  logic             d_read_rt,
    input  logic [T_W-1:0]   d_tuse_rs,
    input  logic [T_W-1:0]   d_tuse_rt,
    input  logic             d_write,
    input  logic [REG_W-1:0] d_des,
    input  logic [T_W-1:0]   d_tnew_e,
    output logic             stall,
    output logic [1:0]       fwd_rs,
    output logic [1:0]       fwd_rt,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int c_NUM_ST = 3;  // index 0 = E, 1 = M, 2 = W

    logic [c_NUM_ST-1:0] r_v;
    logic [REG_W-1:0]    r_des  [c_NUM_ST];
    logic [T_W-1:0]      r_tnew [c_NUM_ST];

    logic [REG_W-1:0]    w_src  [2];
    logic [1:0]          w_rd;
    logic [T_W-1:0]      w_tuse [2];
    logic [1:0]          w_src_stall;
    logic [1:0]          w_fwd  [2];
    logic                w_stall;

    function automatic logic [T_W-1:0] sat_dec(input logic [T_W-1:0] t);
        return (t == '0) ? '0 : t - T_W'(1);
    endfunction

    assign w_src[0]  = d_rs;
    assign w_src[1]  = d_rt;
    assign w_rd      = {d_read_rt, d_read_rs};
    assign w_tuse[0] = d_tuse_rs;
    assign w_tuse[1] = d_tuse_rt;

    for (genvar i = 0; i < 2; i++) begin : g_src
        logic           w_hit;
        logic [1:0]     w_code;
        logic [T_W-1:0] w_tnew;

        // Walk oldest to youngest so the youngest match overwrites older ones.
        always_comb begin
            w_hit  = 1'b0;
            w_code = 2'd0;
            w_tnew = '0;
            for (int k = c_NUM_ST - 1; k >= 0; k--) begin
                if (r_v[k] && (r_des[k] == w_src[i]) && (w_src[i] != '0) && w_rd[i]) begin
                    w_hit  = 1'b1;
                    w_code = 2'(k + 1);
                    w_tnew = r_tnew[k];
                end
            end
        end

        assign w_src_stall[i] = w_hit && (w_tnew > w_tuse[i]);
        assign w_fwd[i]       = (w_hit && (w_tnew == '0)) ? w_code : 2'd0;
    end

    assign w_stall = d_valid && (w_src_stall != 2'b00);
    assign stall   = w_stall;
    assign fwd_rs  = w_fwd[0];
    assign fwd_rt  = w_fwd[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_v <= '0;
            for (int k = 0; k < c_NUM_ST; k++) begin
                r_des[k]  <= '0;
                r_tnew[k] <= '0;
            end
        end else begin
            r_v[2]    <= r_v[1];
            r_des[2]  <= r_des[1];
            r_tnew[2] <= sat_dec(r_tnew[1]);
            r_v[1]    <= r_v[0];
            r_des[1]  <= r_des[0];
            r_tnew[1] <= sat_dec(r_tnew[0]);
            if (w_stall) begin
                r_v[0]    <= 1'b0;
                r_des[0]  <= '0;
                r_tnew[0] <= '0;
            end else begin
                r_v[0]    <= d_valid && d_write && (d_des != '0);
                r_des[0]  <= d_des;
                r_tnew[0] <= d_tnew_e;
            end
        end
    end

`ifdef STALL_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (w_stall) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = '0;
`endif

endmodule
`default_nettype wire
